keypad_key_fifo: RTL
====================

# keypad_key_fifo

Downstream consumer of the keypad scanner's `interrupt` / `keypad_data` outputs. Detects each new key event and queues its 4-bit key code in a small FIFO. Presents the codes to the rest of the design (display or command logic) through a valid/ready handshake, so no key press is lost while the consumer is busy. Reports occupancy and a sticky overflow flag.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO entries; power of 2, ≥ 2.
- `KEY_W`, 4 — key code width; matches the scanner's `keypad_data`.

Ports:
- `clk`  in  1  — single system clock; all logic on rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `key_interrupt`  in  1  — scanner's `interrupt`; high while a decoded key is valid.
- `key_data`  in  `KEY_W`  — scanner's `keypad_data`; valid whenever `key_interrupt` is high.
- `flush`  in  1  — synchronous clear of all queued entries.
- `clear_overflow`  in  1  — synchronous clear of `overflow`.
- `out_ready`  in  1  — consumer accepts `out_data` this cycle.
- `out_valid`  out  1  — FIFO non-empty; `out_data` is valid.
- `out_data`  out  `KEY_W`  — oldest queued key code.
- `count`  out  `$clog2(DEPTH)+1`  — current occupancy, 0..DEPTH.
- `full`  out  1  — `count == DEPTH`.
- `overflow`  out  1  — sticky; a key event was dropped.

## Operation
- Event detect: register `int_q` holds the previous `key_interrupt`.
  - Push request `push = key_interrupt & ~int_q`, i.e. a rising edge.
  - A held interrupt yields exactly one push.
  - `key_data` is sampled in the same cycle as the edge.
- Pop: `pop = out_valid & out_ready`.
- Storage: circular buffer with `$clog2(DEPTH)`-bit read and write pointers that wrap modulo DEPTH, plus a separate `count` register.
- `out_data` is the entry at the read pointer. While the FIFO is empty it holds its last value; consumers qualify it with `out_valid`.
- Per-cycle behaviour, in priority order:
  - `flush`: pointers and `count` go to 0, and this cycle's push and pop are discarded. `overflow` is unaffected except by `clear_overflow`.
  - Push and pop, not full: write and read both happen; `count` unchanged.
  - Push and pop, full: both happen, with no overflow and `count` staying DEPTH. The slot freed by the read is the slot written.
  - Push only, not full: write at the write pointer, advance it, `count+1`.
  - Push only, full: entry dropped, `overflow` set to 1; pointers and `count` unchanged.
  - Pop only: advance the read pointer, `count-1`.
  - Push while empty: the entry is written, `count` becomes 1. The new code appears on `out_data` the next cycle; there is no bypass.
- Overflow: set by a dropped push. Cleared by `clear_overflow`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - `int_q` = 0, pointers = 0, `count` = 0.
  - `out_valid` = 0, `full` = 0, `overflow` = 0, `out_data` = 0.
  - Storage array contents are don't-care.
- If `key_interrupt` is high in the first cycle after reset deassertion, it counts as a new event.
- Latency: edge sampled at posedge N → `out_valid`/`count` updated after posedge N, visible in cycle N+1.
- Pop at posedge M → next entry (or `out_valid` = 0) visible in cycle M+1. Sustained throughput is one pop per cycle.
- `out_valid`, `full`, and `count` are registered or decoded directly from registers, with no combinational path from inputs.
- `out_data` depends only on the read pointer and storage, with no input-to-output combinational path.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); queued keys are lost.

## Structure
- Shared include `keypad_defs.vh`:
  - `KEY_W` = 4.
  - Default FIFO depth.
  - Key code constants 0x0–0xF, shared with the scanner.
- Sub-module `keypad_edge_detect`: holds `int_q` and produces the `push` pulse, with `clk`/`reset` ports. Reusable for other strobe inputs.
- All remaining logic (pointers, count, storage, flags) lives in `keypad_key_fifo`. Expected size is roughly 150–200 lines in total.

## Test plan
- Single key: with `out_ready` = 0, raise `key_interrupt` with `key_data` = 0x5 and hold it for 10 cycles → exactly one entry, `count` = 1, `out_valid` = 1 in cycle N+1, `out_data` = 0x5.
- Order and wrap: push 0x1, 0x2, 0x3, pop two, push 0x4, 0x5, 0x6, then pop all → output sequence 1, 2, 3, 4, 5, 6; pointers wrap with no corruption; `count` ends at 0.
- Full and overflow: push 0xA, 0xB, 0xC, 0xD, 0xE with no pops (DEPTH = 4) → `full` = 1, `overflow` = 1, 0xE dropped. Pops return A, B, C, D. `clear_overflow` then drops `overflow` to 0.
- Simultaneous events:
  - Full FIFO with push 0x7 and pop in the same cycle → `count` stays 4, no overflow, 0x7 emerges last.
  - Overflow set and `clear_overflow` in the same cycle → `overflow` = 1.
- Flush and reset: with 3 entries queued, assert `flush` together with a push → `count` = 0, `out_valid` = 0. Refill 2 entries, then assert `reset` mid-cycle → all outputs return to 0 immediately.

Source files
------------

// File: rtl/keypad_key_fifo_pkg.sv
// Shared definitions for the keypad key FIFO: key code width, default
// depth, the 16 key code values used by the scanner, and the per-cycle
// FIFO operation encoding.
package keypad_key_fifo_pkg;

    localparam int KEY_W_DEF = 4;
    localparam int DEPTH_DEF = 4;

    // Key codes shared with the keypad scanner.
    typedef enum logic [3:0] {
        KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3,
        KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7,
        KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB,
        KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF
    } key_code_e;

    // What the FIFO does in a given cycle, already resolved by priority.
    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_FLUSH = 3'd1,
        OP_BOTH  = 3'd2,
        OP_PUSH  = 3'd3,
        OP_DROP  = 3'd4,
        OP_POP   = 3'd5
    } fifo_op_e;

endpackage

// File: rtl/keypad_edge_detect.sv
// Rising-edge detector for a level strobe: one pulse per low-to-high
// transition, so a held strobe produces exactly one event.
module keypad_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic pulse
);

    logic strobe_q_r;

    // Remember the previous strobe level; cleared so a strobe already high
    // right after reset still counts as a new event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q_r <= 1'b0;
        end else begin
            strobe_q_r <= strobe;
        end
    end

    assign pulse = strobe & ~strobe_q_r;

endmodule

// File: rtl/keypad_key_fifo.sv
// Key event FIFO: captures each new scanner key event and queues the code
// for a valid/ready consumer. Reports occupancy, full, and a sticky
// overflow flag raised when an event had to be dropped.
module keypad_key_fifo
    import keypad_key_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_interrupt,
    input  logic [KEY_W-1:0]         key_data,
    input  logic                     flush,
    input  logic                     clear_overflow,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [KEY_W-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [KEY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    logic [KEY_W-1:0] out_data_r;

    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             valid_s;
    fifo_op_e         op_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic             wr_en_s;
    logic             overflow_next_s;
    logic [KEY_W-1:0] out_data_next_s;

    keypad_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .strobe (key_interrupt),
        .pulse  (push_s)
    );

    assign valid_s = (count_r != CNT_ZERO);
    assign full_s  = (count_r == CNT_DEPTH);
    assign pop_s   = valid_s & out_ready;

    // Resolve this cycle's push/pop/flush into a single prioritised operation.
    always_comb begin
        op_s = OP_IDLE;
        if (flush) begin
            op_s = OP_FLUSH;
        end else if (push_s && pop_s) begin
            op_s = OP_BOTH;
        end else if (push_s && full_s) begin
            op_s = OP_DROP;
        end else if (push_s) begin
            op_s = OP_PUSH;
        end else if (pop_s) begin
            op_s = OP_POP;
        end else begin
            op_s = OP_IDLE;
        end
    end

    // Next pointers, occupancy, write enable and overflow for the chosen operation.
    always_comb begin
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        count_next_s  = count_r;
        wr_en_s       = 1'b0;
        case (op_s)
            OP_FLUSH: begin
                rd_ptr_next_s = {PTR_W{1'b0}};
                wr_ptr_next_s = {PTR_W{1'b0}};
                count_next_s  = CNT_ZERO;
            end
            OP_BOTH: begin
                // When full the slot freed by the read is the one written.
                wr_en_s       = 1'b1;
                wr_ptr_next_s = wr_ptr_r + PTR_ONE;
                rd_ptr_next_s = rd_ptr_r + PTR_ONE;
            end
            OP_PUSH: begin
                wr_en_s       = 1'b1;
                wr_ptr_next_s = wr_ptr_r + PTR_ONE;
                count_next_s  = count_r + CNT_ONE;
            end
            OP_POP: begin
                rd_ptr_next_s = rd_ptr_r + PTR_ONE;
                count_next_s  = count_r - CNT_ONE;
            end
            OP_DROP: begin
                count_next_s  = count_r;
            end
            OP_IDLE: begin
                count_next_s  = count_r;
            end
            default: begin
                count_next_s  = count_r;
            end
        endcase

        // A dropped event beats a same-cycle clear.
        if (op_s == OP_DROP) begin
            overflow_next_s = 1'b1;
        end else if (clear_overflow) begin
            overflow_next_s = 1'b0;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Registered head-of-queue value; holds its last value when the FIFO empties.
    always_comb begin
        out_data_next_s = out_data_r;
        if (count_next_s == CNT_ZERO) begin
            out_data_next_s = out_data_r;
        end else if (wr_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
            out_data_next_s = key_data;
        end else begin
            out_data_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Storage array; contents need no reset since only counted entries are read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= key_data;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
            out_data_r <= {KEY_W{1'b0}};
        end else begin
            rd_ptr_r   <= rd_ptr_next_s;
            wr_ptr_r   <= wr_ptr_next_s;
            count_r    <= count_next_s;
            overflow_r <= overflow_next_s;
            out_data_r <= out_data_next_s;
        end
    end

    assign out_valid = valid_s;
    assign out_data  = out_data_r;
    assign count     = count_r;
    assign full      = full_s;
    assign overflow  = overflow_r;

endmodule
